alu_muldiv: RTL

- Parametrised, multi-cycle successor to the datapath ALU.
- Adds XOR, NOR, signed/unsigned set-less-than, iterative multiply and divide into HI/LO, and MFHI/MFLO reads.
- Sits in the execute stage. The controller raises start, holds the operation while busy, and samples alu_result/zero on done.
- Targets the planned multi-cycle MIPS core.

---
 rtl/alu_muldiv.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - multi-cycle ALU with iterative multiply/divide into HI/LO
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 is_div_q;
    logic                 is_signed_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic                 div0_q;
    logic [WIDTH-1:0]     alu_result_q;
    logic                 done_q;
    logic                 busy_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Request decode: 10xx are the mul/div ops; bit 1 selects divide, bit 0 signed.
    logic             is_md;
    logic             md_div;
    logic             md_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign is_md     = alu_control[3] & ~alu_control[2];
    assign md_div    = alu_control[1];
    assign md_signed = alu_control[0];
    assign mag_a     = src_a[WIDTH-1] ? -src_a : src_a;
    assign mag_b     = src_b[WIDTH-1] ? -src_b : src_b;
    assign op_a      = md_signed ? mag_a : src_a;
    assign op_b      = md_signed ? mag_b : src_b;

    logic [WIDTH-1:0] single_d;

    always_comb begin
        single_d = '0;
        case (alu_control)
            OP_AND:  single_d = src_a & src_b;
            OP_OR:   single_d = src_a | src_b;
            OP_ADD:  single_d = src_a + src_b;
            OP_SUB:  single_d = src_a - src_b;
            OP_XOR:  single_d = src_a ^ src_b;
            OP_NOR:  single_d = ~(src_a | src_b);
            OP_SLT:  single_d = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: single_d = {{(WIDTH-1){1'b0}}, src_a < src_b};
            OP_MFHI: single_d = hi_q;
            OP_MFLO: single_d = lo_q;
            default: single_d = '0;
        endcase
    end

    // One iteration step; acc holds {partial, multiplier} or {remainder, quotient}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_d;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    assign step_d    = is_div_q ? div_next : mul_next;

    // The last of the WIDTH steps is folded into FIN, so MUL/DIV hold for WIDTH-1 cycles.
    logic [2*WIDTH-1:0] fin_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               sign_diff;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    assign fin_raw   = div0_q ? acc_q : step_d;
    assign sign_diff = is_signed_q & (sign_a_q ^ sign_b_q) & ~div0_q;
    assign prod_fix  = sign_diff ? -fin_raw : fin_raw;
    assign quo_fix   = sign_diff ? -fin_raw[WIDTH-1:0] : fin_raw[WIDTH-1:0];
    assign rem_fix   = (is_signed_q & sign_a_q & ~div0_q) ? -fin_raw[2*WIDTH-1:WIDTH]
                                                         : fin_raw[2*WIDTH-1:WIDTH];
    assign hi_d      = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_d      = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opnd_q       <= '0;
            is_div_q     <= 1'b0;
            is_signed_q  <= 1'b0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            div0_q       <= 1'b0;
            alu_result_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            busy_q      <= 1'b1;
                            cnt_q       <= '0;
                            is_div_q    <= md_div;
                            is_signed_q <= md_signed;
                            sign_a_q    <= src_a[WIDTH-1];
                            sign_b_q    <= src_b[WIDTH-1];
                            opnd_q      <= md_div ? op_b : op_a;
                            if (md_div && (src_b == '0)) begin
                                div0_q  <= 1'b1;
                                acc_q   <= {src_a, {WIDTH{1'b1}}};
                                state_q <= S_FIN;
                            end else begin
                                div0_q  <= 1'b0;
                                acc_q   <= {{WIDTH{1'b0}}, md_div ? op_a : op_b};
                                state_q <= md_div ? S_DIV : S_MUL;
                            end
                        end else begin
                            alu_result_q <= single_d;
                            done_q       <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-2)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_result = alu_result_q;
    assign zero       = (alu_result_q == '0);
    assign busy       = busy_q;
    assign done       = done_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule
